rrf: RTL

//  Rename register file: holds speculative results for RRF_ENT_NUM in-flight destinations; sits beside arf.
//  - Allocates up to 2 tags per cycle in order to dispatch (feeds i_dp_ptr_1/2 of the rename table).
//  - Captures execution write-back and serves dispatch operand reads.
//  - Frees up to 2 entries per cycle at commit, supplying commit data (feeds i_com_rd_wr_data_1/2 of arf).

---
 rtl/rrf.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rrf.sv
// Rename register file: a ring of speculative result entries allocated in order at
// dispatch, filled by write-back, read by dispatch operands and freed in order at commit.
module rrf #(
    parameter int RRF_ENT_NUM = 64,
    parameter int RRF_ENT_SEL = 6,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_dp_alloc_en,
    input  logic [1:0]             i_dp_req_num,
    output logic                   o_dp_alloc_rdy,
    output logic [RRF_ENT_SEL-1:0] o_dp_ptr_1,
    output logic [RRF_ENT_SEL-1:0] o_dp_ptr_2,
    input  logic [RRF_ENT_SEL-1:0] i_dp_rd_rrftag_1,
    input  logic [RRF_ENT_SEL-1:0] i_dp_rd_rrftag_2,
    input  logic [RRF_ENT_SEL-1:0] i_dp_rd_rrftag_3,
    input  logic [RRF_ENT_SEL-1:0] i_dp_rd_rrftag_4,
    output logic                   o_dp_rd_vld_1,
    output logic                   o_dp_rd_vld_2,
    output logic                   o_dp_rd_vld_3,
    output logic                   o_dp_rd_vld_4,
    output logic [DATA_WIDTH-1:0]  o_dp_rd_data_1,
    output logic [DATA_WIDTH-1:0]  o_dp_rd_data_2,
    output logic [DATA_WIDTH-1:0]  o_dp_rd_data_3,
    output logic [DATA_WIDTH-1:0]  o_dp_rd_data_4,
    input  logic                   i_wb_vld_1,
    input  logic                   i_wb_vld_2,
    input  logic [RRF_ENT_SEL-1:0] i_wb_rrftag_1,
    input  logic [RRF_ENT_SEL-1:0] i_wb_rrftag_2,
    input  logic [DATA_WIDTH-1:0]  i_wb_data_1,
    input  logic [DATA_WIDTH-1:0]  i_wb_data_2,
    input  logic [1:0]             i_com_num,
    output logic [RRF_ENT_SEL-1:0] o_com_ptr_1,
    output logic [RRF_ENT_SEL-1:0] o_com_ptr_2,
    output logic [DATA_WIDTH-1:0]  o_com_data_1,
    output logic [DATA_WIDTH-1:0]  o_com_data_2,
    input  logic                   i_flush,
    output logic [RRF_ENT_SEL:0]   o_free_num
);

    typedef logic [RRF_ENT_SEL-1:0] tag_t;
    typedef logic [RRF_ENT_SEL:0]   cnt_t;

    localparam tag_t TAG_ONE  = tag_t'(1);
    localparam cnt_t FREE_MAX = cnt_t'(RRF_ENT_NUM);

    tag_t                  alloc_ptr_q;
    tag_t                  alloc_ptr_2;
    tag_t                  com_ptr_q;
    tag_t                  com_ptr_2;
    tag_t                  com_ptr_next;
    cnt_t                  free_q;
    logic [1:0]            alloc_num;
    logic [RRF_ENT_NUM-1:0] valid_q;
    logic [RRF_ENT_NUM-1:0] valid_d;
    logic [DATA_WIDTH-1:0] data_q [RRF_ENT_NUM];

    assign alloc_ptr_2  = alloc_ptr_q + TAG_ONE;
    assign com_ptr_2    = com_ptr_q + TAG_ONE;
    assign com_ptr_next = com_ptr_q + tag_t'(i_com_num);

    // Readiness looks only at the registered free count; same-cycle commits are not credited.
    assign o_dp_alloc_rdy = (free_q >= cnt_t'(i_dp_req_num));
    assign alloc_num      = (i_dp_alloc_en && o_dp_alloc_rdy) ? i_dp_req_num : 2'd0;

    assign o_dp_ptr_1   = alloc_ptr_q;
    assign o_dp_ptr_2   = alloc_ptr_2;
    assign o_com_ptr_1  = com_ptr_q;
    assign o_com_ptr_2  = com_ptr_2;
    assign o_com_data_1 = data_q[com_ptr_q];
    assign o_com_data_2 = data_q[com_ptr_2];
    assign o_free_num   = free_q;

    function automatic logic [DATA_WIDTH:0] rd_port(input tag_t tag);
        if (i_wb_vld_1 && (i_wb_rrftag_1 == tag)) return {1'b1, i_wb_data_1};
        if (i_wb_vld_2 && (i_wb_rrftag_2 == tag)) return {1'b1, i_wb_data_2};
        return {valid_q[tag], data_q[tag]};
    endfunction

    always_comb begin
        {o_dp_rd_vld_1, o_dp_rd_data_1} = rd_port(i_dp_rd_rrftag_1);
        {o_dp_rd_vld_2, o_dp_rd_data_2} = rd_port(i_dp_rd_rrftag_2);
        {o_dp_rd_vld_3, o_dp_rd_data_3} = rd_port(i_dp_rd_rrftag_3);
        {o_dp_rd_vld_4, o_dp_rd_data_4} = rd_port(i_dp_rd_rrftag_4);
    end

    // Later statements override earlier ones: allocation clears beat write-back sets.
    always_comb begin
        // NOTE: start from the held value so every path assigns valid_d and no latch is inferred.
        valid_d = valid_q;
        if (i_wb_vld_1) valid_d[i_wb_rrftag_1] = 1'b1;
        if (i_wb_vld_2) valid_d[i_wb_rrftag_2] = 1'b1;
        if (i_com_num != 2'd0) valid_d[com_ptr_q] = 1'b0;
        if (i_com_num == 2'd2) valid_d[com_ptr_2] = 1'b0;
        if (alloc_num != 2'd0) valid_d[alloc_ptr_q] = 1'b0;
        if (alloc_num == 2'd2) valid_d[alloc_ptr_2] = 1'b0;
        if (i_flush) valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr_q <= '0;
            com_ptr_q   <= '0;
            free_q      <= FREE_MAX;
            valid_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            com_ptr_q <= com_ptr_next;
            valid_q   <= valid_d;
            if (i_flush) begin
                alloc_ptr_q <= com_ptr_next;
                free_q      <= FREE_MAX;
            end else begin
                alloc_ptr_q <= alloc_ptr_q + tag_t'(alloc_num);
                free_q      <= free_q - cnt_t'(alloc_num) + cnt_t'(i_com_num);
            end
        end
    end

    // NOTE: the data array is reset because commit data of never-written entries must read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RRF_ENT_NUM; i++) data_q[i] <= '0;
        end else begin
            if (i_wb_vld_1) data_q[i_wb_rrftag_1] <= i_wb_data_1;
            if (i_wb_vld_2) data_q[i_wb_rrftag_2] <= i_wb_data_2;
        end
    end

    a_com_1_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (i_com_num != 2'd0) |-> valid_q[com_ptr_q]);
    a_com_2_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (i_com_num == 2'd2) |-> valid_q[com_ptr_2]);
    a_com_num_legal: assert property (@(posedge clk) disable iff (!rst_n)
        i_com_num != 2'd3);
    a_req_num_legal: assert property (@(posedge clk) disable iff (!rst_n)
        i_dp_alloc_en |-> (i_dp_req_num != 2'd3));

endmodule
